// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator side of the one-hot ALU interface. Accepts a binary-coded ALU
// operation over a valid/ready request channel, encodes it to the 12-bit
// one-hot alu_control (bit 11-op set), drives the combinational ALU for
// SETTLE_CYCLES cycles, captures alu_result and hands it back over a
// valid/ready response channel. Illegal opcodes (12..15) bypass the ALU and
// are answered immediately with resp_err=1.
//
// Optional build macro: ALU_SEQ_CHECK_EN
//   Defined   -> an internal reference model checks alu_result on capture and
//                reports the outcome on resp_mismatch.
//   Undefined -> resp_mismatch is tied low and no model is built.
//
// Parameters
//   SETTLE_CYCLES  cycles alu_* is driven before alu_result is sampled (1..15)
//   CNT_W          width of the completed-operation counter
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   req_valid/req_ready      request handshake
//   req_op         binary opcode 0..11 (12..15 illegal)
//   req_src1/req_src2        operands (shift amount in req_src1[4:0])
//   alu_control    one-hot op select to the ALU
//   alu_src1/alu_src2        operands to the ALU
//   alu_result     combinational ALU result
//   resp_valid/resp_ready    response handshake
//   resp_result    captured result (0 for illegal ops)
//   resp_err       request carried an illegal opcode
//   resp_mismatch  ALU result disagreed with the reference model
//   op_count       completed responses, wraps silently
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    output logic [11:0]      alu_control,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    input  logic [31:0]      alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic             resp_err,
    output logic             resp_mismatch,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter reload so that the capture edge lands exactly SETTLE_CYCLES
    // edges after the accept edge.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_settle_cnt;
    logic [11:0]        r_alu_control;
    logic [31:0]        r_alu_src1;
    logic [31:0]        r_alu_src2;
    logic [31:0]        r_resp_result;
    logic               r_resp_err;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_op_legal;
    logic [11:0]        w_onehot;
    logic               w_accept;
    logic               w_capture;
    logic               w_handoff;
    logic               w_req_ready;
    logic               w_resp_valid;

    assign w_op_legal = (req_op < 4'd12);
    assign w_onehot   = 12'h800 >> req_op;
    assign w_accept   = (r_state == IDLE) && req_valid;
    assign w_capture  = (r_state == EXEC) && (r_settle_cnt == 4'd0);
    assign w_handoff  = (r_state == RESP) && resp_ready;

    // ---------------------------------------------------------------- FSM
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = w_op_legal ? EXEC : RESP;
            EXEC:    if (r_settle_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            IDLE:    w_req_ready  = 1'b1;
            RESP:    w_resp_valid = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // NOTE: every register here is small control/data state, so all of it is
    // reset; nothing is large enough to warrant leaving it uninitialised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt  <= 4'd0;
            r_alu_control <= 12'h000;
            r_alu_src1    <= 32'h0;
            r_alu_src2    <= 32'h0;
            r_resp_result <= 32'h0;
            r_resp_err    <= 1'b0;
            r_op_count    <= '0;
        end else begin
            if (w_accept) begin
                if (w_op_legal) begin
                    r_alu_control <= w_onehot;
                    r_alu_src1    <= req_src1;
                    r_alu_src2    <= req_src2;
                    r_settle_cnt  <= SETTLE_LOAD;
                end else begin
                    // Illegal op never reaches the ALU: keep its inputs at 0.
                    r_alu_control <= 12'h000;
                    r_alu_src1    <= 32'h0;
                    r_alu_src2    <= 32'h0;
                    r_resp_result <= 32'h0;
                    r_resp_err    <= 1'b1;
                end
            end

            if ((r_state == EXEC) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end

            if (w_capture) begin
                r_resp_result <= alu_result;
                r_resp_err    <= 1'b0;
            end

            if (w_handoff) begin
                r_alu_control <= 12'h000;
                r_op_count    <= r_op_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------ self-check model
`ifdef ALU_SEQ_CHECK_EN
    logic r_resp_mismatch;

    function automatic logic [31:0] ref_result(
        input logic [11:0] ctrl,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] res;
        res = 32'h0;
        case (ctrl)
            12'h800: res = a + b;
            12'h400: res = a - b;
            12'h200: res = {31'h0, $signed(a) < $signed(b)};
            12'h100: res = {31'h0, a < b};
            12'h080: res = a & b;
            12'h040: res = ~(a | b);
            12'h020: res = a | b;
            12'h010: res = a ^ b;
            12'h008: res = b << a[4:0];
            12'h004: res = b >> a[4:0];
            12'h002: res = 32'($signed(b) >>> a[4:0]);
            12'h001: res = {b[15:0], 16'h0};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_mismatch <= 1'b0;
        end else if (w_capture) begin
            r_resp_mismatch <= (alu_result != ref_result(r_alu_control, r_alu_src1, r_alu_src2));
        end else if (w_accept || w_handoff) begin
            // Illegal-op responses and the return to IDLE both read as clean.
            r_resp_mismatch <= 1'b0;
        end
    end

    assign resp_mismatch = r_resp_mismatch;
`else
    assign resp_mismatch = 1'b0;
`endif

    // -------------------------------------------------------------- outputs
    assign req_ready   = w_req_ready;
    assign resp_valid  = w_resp_valid;
    assign alu_control = r_alu_control;
    assign alu_src1    = r_alu_src1;
    assign alu_src2    = r_alu_src2;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Two instances: u_dut (SETTLE_CYCLES=1) is checked every cycle against a
// transaction-level model; u_dut4 (SETTLE_CYCLES=4) covers settle latency and
// reset during EXEC. The bench plays the ALU for both instances, with a fault
// switch that breaks the AND operation for the self-check case.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    localparam int CW = 16;
`ifdef ALU_SEQ_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each binary opcode.
    function automatic logic [31:0] model_result(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << a[4:0];
            9:  return b >> a[4:0];
            10: return 32'($signed(b) >>> a[4:0]);
            11: return {b[15:0], 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int oh_to_op(input logic [11:0] c);
        for (int i = 0; i < 12; i++) begin
            if (c == (12'h800 >> i)) return i;
        end
        return 15;
    endfunction

    // ------------------------------------------------------------ u_dut
    logic            reset;
    logic            req_valid, req_ready;
    logic [3:0]      req_op;
    logic [31:0]     req_src1, req_src2;
    logic [11:0]     alu_control;
    logic [31:0]     alu_src1, alu_src2, alu_result;
    logic            resp_valid, resp_ready;
    logic [31:0]     resp_result;
    logic            resp_err, resp_mismatch;
    logic [CW-1:0]   op_count;
    logic            alu_fault;

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_err(resp_err), .resp_mismatch(resp_mismatch), .op_count(op_count)
    );

    always_comb begin
        if (alu_fault && oh_to_op(alu_control) == 4) alu_result = 32'h0;
        else alu_result = model_result(oh_to_op(alu_control), alu_src1, alu_src2);
    end

    // ----------------------------------------------------------- u_dut4
    logic            rst4;
    logic            req_valid4, req_ready4;
    logic [3:0]      req_op4;
    logic [31:0]     req_src1_4, req_src2_4;
    logic [11:0]     alu_control4;
    logic [31:0]     alu_src1_4, alu_src2_4, alu_result4;
    logic            resp_valid4, resp_ready4;
    logic [31:0]     resp_result4;
    logic            resp_err4, resp_mismatch4;
    logic [CW-1:0]   op_count4;

    alu_op_sequencer #(.SETTLE_CYCLES(4), .CNT_W(CW)) u_dut4 (
        .clk(clk), .reset(rst4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op4),
        .req_src1(req_src1_4), .req_src2(req_src2_4),
        .alu_control(alu_control4), .alu_src1(alu_src1_4), .alu_src2(alu_src2_4),
        .alu_result(alu_result4),
        .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_result(resp_result4),
        .resp_err(resp_err4), .resp_mismatch(resp_mismatch4), .op_count(op_count4)
    );

    always_comb alu_result4 = model_result(oh_to_op(alu_control4), alu_src1_4, alu_src2_4);

    // --------------------------------------------- transaction model (u_dut)
    // One outstanding transaction with a due cycle: a legal op becomes visible
    // one cycle after acceptance, an illegal op immediately.
    int            cyc;
    bit            m_busy;
    int            m_ready_at;
    logic [11:0]   m_ctrl;
    logic [31:0]   m_s1, m_s2, m_res;
    bit            m_err, m_mis;
    logic [CW-1:0] m_count;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc <= 0; m_busy <= 1'b0; m_ready_at <= 0; m_count <= '0;
            m_ctrl <= '0; m_s1 <= '0; m_s2 <= '0; m_res <= '0; m_err <= 1'b0; m_mis <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_busy && cyc >= m_ready_at && resp_ready) begin
                m_busy  <= 1'b0;
                m_count <= m_count + 1'b1;
            end else if (!m_busy && req_valid) begin
                m_busy <= 1'b1;
                if (req_op > 4'd11) begin
                    m_err <= 1'b1; m_ready_at <= cyc + 1;
                    m_ctrl <= '0; m_s1 <= '0; m_s2 <= '0; m_res <= '0; m_mis <= 1'b0;
                end else begin
                    m_err <= 1'b0; m_ready_at <= cyc + 2;
                    m_ctrl <= 12'd1 << (11 - req_op);
                    m_s1 <= req_src1; m_s2 <= req_src2;
                    if (alu_fault && req_op == 4'd4) begin
                        m_res <= 32'h0;
                        m_mis <= CHK_EN && (model_result(4, req_src1, req_src2) != 32'h0);
                    end else begin
                        m_res <= model_result(int'(req_op), req_src1, req_src2);
                        m_mis <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("req_ready", req_ready, !m_busy);
            check("resp_valid", resp_valid, m_busy && cyc >= m_ready_at);
            check("op_count", op_count, m_count);
            check("alu_control", alu_control, m_busy ? m_ctrl : 12'h0);
            if (m_busy) begin
                check("alu_src1", alu_src1, m_s1);
                check("alu_src2", alu_src2, m_s2);
            end
            if (m_busy && cyc >= m_ready_at) begin
                check("resp_result", resp_result, m_res);
                check("resp_err", resp_err, m_err);
                check("resp_mismatch", resp_mismatch, m_mis);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("send_ready_timeout", req_ready, 1'b1);
        req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9] = '{
        '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},  // slt  -1 < 1
        '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},  // sltu
        '{4'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000},  // and
        '{4'd5,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF},  // nor
        '{4'd6,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF},  // or
        '{4'd7,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0},  // xor
        '{4'd8,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010},  // sll
        '{4'd9,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000},  // srl
        '{4'd11, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000}   // lui
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rst4 = 1'b0; alu_fault = 1'b0;
        req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; resp_ready = 1'b1;
        req_valid4 = 1'b0; req_op4 = '0; req_src1_4 = '0; req_src2_4 = '0; resp_ready4 = 1'b1;
        #1 reset = 1'b1; rst4 = 1'b1;
        #2;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_alu_control", alu_control, 12'h0);
        check("rst_alu_src1", alu_src1, 32'h0);
        check("rst_alu_src2", alu_src2, 32'h0);
        check("rst_resp_result", resp_result, 32'h0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_mismatch", resp_mismatch, 1'b0);
        check("rst_op_count", op_count, 16'h0);
        #19 reset = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;

        // Pin the model itself to hand-computed values.
        check("model_add", model_result(0, 32'h1, 32'h2), 32'h3);
        check("model_sub", model_result(1, 32'h1, 32'h2), 32'hFFFF_FFFF);
        check("model_sra", model_result(10, 32'h4, 32'h8000_0000), 32'hF800_0000);
        foreach (vecs[i]) check("model_vec", model_result(int'(vecs[i].op), vecs[i].a, vecs[i].b), vecs[i].exp);

        // Add: response one cycle after accept.
        send(4'd0, 32'h1, 32'h2);
        check("add_ctrl", alu_control, 12'b1000_0000_0000);
        check("add_not_yet", resp_valid, 1'b0);
        @(posedge clk); #1;
        check("add_valid", resp_valid, 1'b1);
        check("add_result", resp_result, 32'h3);
        check("add_err", resp_err, 1'b0);
        @(posedge clk); #1;
        check("add_count", op_count, 16'd1);
        check("add_idle", req_ready, 1'b1);

        // Sub then sra.
        send(4'd1, 32'h1, 32'h2);
        @(posedge clk); #1;
        check("sub_result", resp_result, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        send(4'd10, 32'h4, 32'h8000_0000);
        check("sra_ctrl", alu_control, 12'b0000_0000_0010);
        @(posedge clk); #1;
        check("sra_result", resp_result, 32'hF800_0000);
        @(posedge clk); #1;

        // Remaining opcodes.
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            check("vec_result", resp_result, vecs[i].exp);
            @(posedge clk); #1;
        end

        // Illegal opcode: immediate error response, ALU untouched.
        send(4'd13, 32'h5, 32'h6);
        check("ill_valid", resp_valid, 1'b1);
        check("ill_err", resp_err, 1'b1);
        check("ill_result", resp_result, 32'h0);
        check("ill_ctrl", alu_control, 12'h0);
        @(posedge clk); #1;
        check("ill_count", op_count, 16'd13);

        // Backpressure with an ignored request during RESP.
        resp_ready = 1'b0;
        send(4'd6, 32'h0000_00F0, 32'h0000_000F);
        @(posedge clk); #1;
        req_op = 4'd0; req_src1 = 32'h7; req_src2 = 32'h9; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_valid", resp_valid, 1'b1);
            check("bp_ready", req_ready, 1'b0);
            check("bp_result", resp_result, 32'h0000_00FF);
            check("bp_ctrl", alu_control, 12'h020);
            check("bp_src1", alu_src1, 32'h0000_00F0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_idle", req_ready, 1'b1);
        check("bp_done_count", op_count, 16'd14);
        @(posedge clk); #1;
        check("bp_no_ghost", op_count, 16'd14);

        // Self-check: broken AND, then healthy AND.
        alu_fault = 1'b1;
        send(4'd4, 32'h0000_00FF, 32'h0000_000F);
        @(posedge clk); #1;
        check("fault_result", resp_result, 32'h0);
        check("fault_mismatch", resp_mismatch, CHK_EN);
        @(posedge clk); #1;
        alu_fault = 1'b0;
        check("fault_cleared", resp_mismatch, 1'b0);
        send(4'd4, 32'h0000_00FF, 32'h0000_000F);
        @(posedge clk); #1;
        check("good_result", resp_result, 32'h0000_000F);
        check("good_mismatch", resp_mismatch, 1'b0);
        @(posedge clk); #1;
        check("final_count", op_count, 16'd16);

        // u_dut4: latency of exactly four cycles.
        check("d4_ready", req_ready4, 1'b1);
        req_op4 = 4'd0; req_src1_4 = 32'h5; req_src2_4 = 32'h6; req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        check("d4_accept_valid", resp_valid4, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("d4_latency", resp_valid4, k == 4);
            check("d4_ctrl_held", alu_control4, 12'h800);
        end
        check("d4_result", resp_result4, 32'd11);
        @(posedge clk); #1;
        check("d4_count", op_count4, 16'd1);

        // u_dut4: reset two cycles into EXEC drops the op.
        req_op4 = 4'd1; req_src1_4 = 32'h9; req_src2_4 = 32'h3; req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("d4_in_exec", req_ready4, 1'b0);
        rst4 = 1'b1;
        #1;
        check("d4_rst_ready", req_ready4, 1'b1);
        check("d4_rst_valid", resp_valid4, 1'b0);
        check("d4_rst_ctrl", alu_control4, 12'h0);
        check("d4_rst_src1", alu_src1_4, 32'h0);
        check("d4_rst_src2", alu_src2_4, 32'h0);
        check("d4_rst_result", resp_result4, 32'h0);
        check("d4_rst_err", resp_err4, 1'b0);
        check("d4_rst_mismatch", resp_mismatch4, 1'b0);
        check("d4_rst_count", op_count4, 16'h0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("d4_no_resp", resp_valid4, 1'b0);
            check("d4_count_zero", op_count4, 16'h0);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the one-hot ALU interface: accepts binary-coded operation requests over a valid/ready handshake and encodes each to the 12-bit one-hot alu_control.
- Drives alu_control, alu_src1 and alu_src2 into the combinational alu, waits a configurable settle time, registers alu_result, and returns it over a valid/ready response channel.
- Sits between the decode stage and the alu, replacing hand-driven stimulus.

Parameters:
SETTLE_CYCLES, 1, cycles the alu_* drive is held before alu_result is sampled (legal range 1..15)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  4  binary opcode 0..11; 12..15 illegal
req_src1  input  32  operand 1 (shift amount in [4:0] for shifts)
req_src2  input  32  operand 2
alu_control  output  12  one-hot op select to alu
alu_src1  output  32  operand 1 to alu
alu_src2  output  32  operand 2 to alu
alu_result  input  32  combinational alu result
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_result  output  32  captured result
resp_err  output  1  request had an illegal opcode
resp_mismatch  output  1  self-check failure (see Optional Feature)
op_count  output  CNT_W  number of completed responses

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: state=IDLE, req_ready=1, alu_control=0, alu_src1=0, alu_src2=0, resp_valid=0, resp_result=0, resp_err=0, resp_mismatch=0, op_count=0.
- Opcode encoding: alu_control[11-op] is set. Bit mapping:
  - 11 add, 10 sub, 9 slt, 8 sltu
  - 7 and, 6 nor, 5 or, 4 xor
  - 3 sll, 2 srl, 1 sra, 0 lui
- Shift and lui rules: shifts operate on src2 by src1[4:0]; lui returns {src2[15:0],16'h0}.
- State IDLE:
  - req_ready=1.
  - On req_valid with a legal op: register alu_control, alu_src1 and alu_src2 from the request; load settle counter with SETTLE_CYCLES-1; go to EXEC.
  - On req_valid with an illegal op: alu_* outputs stay 0; resp_err=1, resp_result=0; go to RESP.
- State EXEC:
  - req_ready=0 and alu_* outputs are held.
  - The counter decrements each cycle.
  - On the edge where the counter is 0: capture alu_result into resp_result, set resp_valid=1, resp_err=0, go to RESP.
  - Latency from the accept edge to resp_valid high is exactly SETTLE_CYCLES cycles.
- State RESP:
  - resp_valid=1; resp_result and resp_err are stable and alu_* outputs are held.
  - On resp_valid&&resp_ready: resp_valid=0, alu_control=0, op_count increments, go to IDLE.
  - No new request is accepted on that same edge. Throughput is one op per SETTLE_CYCLES+2 cycles at best.
- op_count wraps from all-ones to 0 without flagging.
- req_* inputs are ignored outside IDLE.
- Reset asserted in any state returns everything to the reset values immediately. Any in-flight op is dropped and not counted.
- resp_ready held high continuously is legal; the response lasts exactly one cycle.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- When defined:
  - An internal reference model computes the expected result from the registered op and operands.
  - On the capture edge in EXEC, resp_mismatch is set to (alu_result != expected). It is valid while resp_valid=1 and cleared when leaving RESP.
  - Illegal-op responses always give resp_mismatch=0.
- When undefined: resp_mismatch is tied to 0 and the model is not synthesised.

Test Plan:
- Add: op=0, src1=32'h1, src2=32'h2 -> alu_control=12'b1000_0000_0000; resp_valid one cycle after accept; resp_result=32'h3; resp_err=0; op_count=1.
- Sub and sra: op=1, 32'h1 - 32'h2 -> resp_result=32'hFFFFFFFF. Then op=10, src1=4, src2=32'h80000000 -> resp_result=32'hF8000000 and alu_control=12'b0000_0000_0010.
- Illegal op: op=13 -> alu_control stays 0; resp_err=1; resp_result=0; op_count increments on the handshake.
- Backpressure: hold resp_ready=0 for 3 cycles after resp_valid -> resp_result and alu_* stable, req_ready=0, a new req_valid is ignored. Raising resp_ready completes the op; IDLE follows the next cycle.
- Reset during EXEC with SETTLE_CYCLES=4: assert reset two cycles after accept -> all outputs return to reset values asynchronously; no response is issued; op_count=0.
- Check feature (ALU_SEQ_CHECK_EN defined): the bench alu model returns 32'h0 for op=4 (and) with src1=32'hFF, src2=32'h0F -> resp_mismatch=1; with a correct alu returning 32'h0F -> resp_mismatch=0.
